// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: on a fetch miss it stalls fetch and reads one word from memory.
// It then writes that word into the cache fill port, with flush handling, a timeout and a miss counter.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    input  logic                  cache_hit_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_we_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  err_o,
    output logic [31:0]           miss_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   maddr_reg, maddr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic [TW-1:0]           tmo_reg, tmo_next;
    logic [31:0]             count_reg, count_next;
    logic                    miss;
    logic                    tmo_expired;

    assign miss         = fetch_valid_i & ~cache_hit_i & ~flush_i;
    // ">=" rather than "==": a flush in WAIT at the last cycle still leaves DRAIN bounded
    assign tmo_expired  = (tmo_reg >= TMO_LAST);
    assign miss_count_o = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            maddr_reg <= '0;
            data_reg  <= '0;
            tmo_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            maddr_reg <= maddr_next;
            data_reg  <= data_next;
            tmo_reg   <= tmo_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        maddr_next  = maddr_reg;
        data_next   = data_reg;
        tmo_next    = tmo_reg;
        count_next  = count_reg;
        stall_o     = 1'b1;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        fill_we_o   = 1'b0;
        fill_addr_o = '0;
        fill_data_o = '0;
        err_o       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                stall_o = miss;
                if (miss) begin
                    state_next = S_REQ;
                    maddr_next = fetch_addr_i & ~ADDR_WIDTH'(3);
                    tmo_next   = '0;
                end
            end
            S_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = maddr_reg;
                tmo_next   = tmo_reg + TW'(1);
                if (mem_ack_i) begin
                    state_next = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_next = S_IDLE;
                end else if (tmo_expired) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT: begin
                tmo_next = tmo_reg + TW'(1);
                // Returning data wins over a simultaneous flush: the word is valid for maddr
                if (mem_rvalid_i) begin
                    data_next  = mem_rdata_i;
                    state_next = S_FILL;
                end else if (flush_i) begin
                    state_next = S_DRAIN;
                end else if (tmo_expired) begin
                    state_next = S_ERR;
                end
            end
            S_FILL: begin
                fill_we_o   = 1'b1;
                fill_addr_o = maddr_reg;
                fill_data_o = data_reg;
                if (count_reg != '1) begin
                    count_next = count_reg + 32'd1;
                end
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                tmo_next = tmo_reg + TW'(1);
                if (mem_rvalid_i) begin
                    state_next = S_IDLE;
                end else if (tmo_expired) begin
                    state_next = S_ERR;
                end
            end
            S_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
